// File: rtl/mem_router_pkg.sv
// rtl/mem_router_pkg.sv - shared types and default memory map for mem_region_router
package mem_router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int MAX_REGIONS = 8;

    localparam logic [31:0] TEXT_BASE   = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE   = 32'h1001_0000;
    localparam logic [31:0] DATA_LIMIT  = 32'h1006_FFFC;
    localparam logic [31:0] STACK_BASE  = 32'h7FFE_F000;
    localparam logic [31:0] STACK_LIMIT = 32'h7FFF_EFFC;
    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_LIMIT  = 32'hFFFF_0A60;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_region_router_decoder.sv
// rtl/mem_region_router_decoder.sv - combinational address-window decode with priority select
module region_decoder
    import mem_router_pkg::*;
#(
    parameter int                            N_REGIONS   = 3,
    parameter int                            ADDR_W      = 32,
    parameter int                            OFF_W       = 17,
    parameter logic [N_REGIONS*ADDR_W-1:0]   REGION_BASE  = {MMIO_BASE, STACK_BASE, DATA_BASE},
    parameter logic [N_REGIONS*ADDR_W-1:0]   REGION_LIMIT = {MMIO_LIMIT, STACK_LIMIT, DATA_LIMIT},
    parameter logic [N_REGIONS-1:0]          REGION_DESC  = 3'b010,
    parameter bit                            ALIGN_CHECK  = 1'b1,
    parameter int                            IDX_W        = idx_width(N_REGIONS)
) (
    input  logic [ADDR_W-1:0]    addr,
    output logic [N_REGIONS-1:0] hit,
    output logic [IDX_W-1:0]     idx,
    output logic                 miss,
    output logic                 misaligned,
    output logic [OFF_W-1:0]     offset
);

    logic [ADDR_W-1:0] off_full;
    logic              unused_off;

    always_comb begin
        hit      = '0;
        idx      = '0;
        off_full = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            hit[i] = (addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) &&
                     (addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]);
        end
        // Walk downward so the lowest matching index is the last one written.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx      = IDX_W'(i);
                off_full = REGION_DESC[i] ? (REGION_LIMIT[i*ADDR_W +: ADDR_W] - addr)
                                          : (addr - REGION_BASE[i*ADDR_W +: ADDR_W]);
            end
        end
        miss       = ~|hit;
        misaligned = ALIGN_CHECK && (addr[1:0] != 2'b00);
        offset     = off_full[OFF_W+1:2];
    end

    assign unused_off = ^off_full;

endmodule

// File: rtl/mem_region_router.sv
// rtl/mem_region_router.sv - single-outstanding CPU access router over programmable region windows
module mem_region_router
    import mem_router_pkg::*;
#(
    parameter int                            N_REGIONS    = 3,
    parameter int                            ADDR_W       = 32,
    parameter int                            DATA_W       = 32,
    parameter int                            OFF_W        = 17,
    parameter logic [N_REGIONS*ADDR_W-1:0]   REGION_BASE  = {MMIO_BASE, STACK_BASE, DATA_BASE},
    parameter logic [N_REGIONS*ADDR_W-1:0]   REGION_LIMIT = {MMIO_LIMIT, STACK_LIMIT, DATA_LIMIT},
    parameter logic [N_REGIONS-1:0]          REGION_DESC  = 3'b010,
    parameter logic [N_REGIONS*4-1:0]        REGION_LAT   = {4'd1, 4'd1, 4'd1},
    parameter bit                            ALIGN_CHECK  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          req_wen,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic [N_REGIONS-1:0]          reg_sel,
    output logic [N_REGIONS-1:0]          reg_wen,
    output logic [OFF_W-1:0]              reg_addr,
    output logic [DATA_W-1:0]             reg_wdata,
    input  logic [N_REGIONS*DATA_W-1:0]   reg_rdata,
    input  logic                          fault_clr,
    output logic                          fault_sticky,
    output logic [ADDR_W-1:0]             fault_addr
);

    localparam int IDX_W = idx_width(N_REGIONS);

    if (N_REGIONS < 1 || N_REGIONS > MAX_REGIONS) begin : g_bad_count
        $error("mem_region_router: N_REGIONS out of range");
    end
    for (genvar g = 0; g < N_REGIONS; g++) begin : g_map_chk
        if ((64'(REGION_LIMIT[g*ADDR_W +: ADDR_W] - REGION_BASE[g*ADDR_W +: ADDR_W]) >> 2)
                >= (64'(1) << OFF_W)) begin : g_bad_span
            $error("mem_region_router: region window too large for OFF_W");
        end
        if (REGION_LAT[g*4 +: 4] == 4'd0) begin : g_bad_lat
            $error("mem_region_router: region latency must be non-zero");
        end
    end

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   wen_q, wen_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [N_REGIONS-1:0]   reg_sel_q, reg_sel_d;
    logic [N_REGIONS-1:0]   reg_wen_q, reg_wen_d;
    logic [OFF_W-1:0]       reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]      reg_wdata_q, reg_wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                   fault_sticky_q, fault_sticky_d;
    logic [ADDR_W-1:0]      fault_addr_q, fault_addr_d;

    logic [N_REGIONS-1:0]   dec_hit;
    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_miss, dec_misaligned;
    logic [OFF_W-1:0]       dec_offset;
    logic [N_REGIONS-1:0]   dec_onehot;
    logic [3:0]             dec_lat;
    logic [DATA_W-1:0]      sel_rdata;
    logic                   unused_hit;

    region_decoder #(
        .N_REGIONS    (N_REGIONS),
        .ADDR_W       (ADDR_W),
        .OFF_W        (OFF_W),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .REGION_DESC  (REGION_DESC),
        .ALIGN_CHECK  (ALIGN_CHECK),
        .IDX_W        (IDX_W)
    ) u_decoder (
        .addr       (req_addr),
        .hit        (dec_hit),
        .idx        (dec_idx),
        .miss       (dec_miss),
        .misaligned (dec_misaligned),
        .offset     (dec_offset)
    );

    assign unused_hit = ^dec_hit;
    assign req_ready  = (state_q == IDLE) && rst_n;

    always_comb begin
        dec_onehot = '0;
        dec_lat    = 4'd0;
        sel_rdata  = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (dec_idx == IDX_W'(i)) begin
                dec_onehot[i] = 1'b1;
                dec_lat       = REGION_LAT[i*4 +: 4];
            end
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = reg_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        wen_d          = wen_q;
        cnt_d          = cnt_q;
        reg_sel_d      = '0;
        reg_wen_d      = '0;
        reg_addr_d     = reg_addr_q;
        reg_wdata_d    = reg_wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_err_d      = 1'b0;
        rsp_rdata_d    = '0;
        fault_sticky_d = fault_clr ? 1'b0 : fault_sticky_q;
        fault_addr_d   = fault_addr_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec_miss || dec_misaligned) begin
                        rsp_valid_d    = 1'b1;
                        rsp_err_d      = 1'b1;
                        fault_sticky_d = 1'b1;
                        // A clear in the same cycle lets this fault become the logged one.
                        if (!fault_sticky_q || fault_clr) begin
                            fault_addr_d = req_addr;
                        end
                    end else begin
                        state_d     = ISSUE;
                        idx_d       = dec_idx;
                        wen_d       = req_wen;
                        cnt_d       = dec_lat;
                        reg_sel_d   = dec_onehot;
                        reg_wen_d   = req_wen ? dec_onehot : '0;
                        reg_addr_d  = dec_offset;
                        reg_wdata_d = req_wdata;
                    end
                end
            end
            ISSUE: begin
                if (wen_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = sel_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            wen_q          <= 1'b0;
            cnt_q          <= 4'd0;
            reg_sel_q      <= '0;
            reg_wen_q      <= '0;
            reg_addr_q     <= '0;
            reg_wdata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= '0;
            fault_sticky_q <= 1'b0;
            fault_addr_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            wen_q          <= wen_d;
            cnt_q          <= cnt_d;
            reg_sel_q      <= reg_sel_d;
            reg_wen_q      <= reg_wen_d;
            reg_addr_q     <= reg_addr_d;
            reg_wdata_q    <= reg_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_rdata_q    <= rsp_rdata_d;
            fault_sticky_q <= fault_sticky_d;
            fault_addr_q   <= fault_addr_d;
        end
    end

    assign reg_sel      = reg_sel_q;
    assign reg_wen      = reg_wen_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wdata    = reg_wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign fault_sticky = fault_sticky_q;
    assign fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_mem_region_router.sv
// tb/tb_mem_region_router.sv - directed self-checking bench for mem_region_router
module tb_mem_region_router;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_wen;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [2:0]   reg_sel;
    logic [2:0]   reg_wen;
    logic [16:0]  reg_addr;
    logic [31:0]  reg_wdata;
    logic [95:0]  reg_rdata;
    logic         fault_clr;
    logic         fault_sticky;
    logic [31:0]  fault_addr;

    int checks = 0;
    int errors = 0;

    mem_region_router #(
        .REGION_LAT ({4'd3, 4'd1, 4'd1})
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .reg_sel      (reg_sel),
        .reg_wen      (reg_wen),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .fault_clr    (fault_clr),
        .fault_sticky (fault_sticky),
        .fault_addr   (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
        req_wdata = '0; fault_clr = 1'b0;
        reg_rdata = {32'hCAFE_F00D, 32'h5555_AAAA, 32'hDEAD_BEEF};
        tick(); tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v=%b e=%b want 0/0", rsp_valid, rsp_err); end
        checks++; if (reg_sel !== 3'b000 || reg_addr !== 17'd0) begin errors++; $display("FAIL reset_reg: got sel=%b addr=%h want 0/0", reg_sel, reg_addr); end
        checks++; if (fault_sticky !== 1'b0 || fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault: got %b %h want 0 0", fault_sticky, fault_addr); end
        rst_n = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_load_data();
        req_valid = 1'b1; req_addr = 32'h1001_0008; req_wen = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++; if (reg_sel !== 3'b001 || reg_wen !== 3'b000) begin errors++; $display("FAIL load_sel: got sel=%b wen=%b want 001/000", reg_sel, reg_wen); end
        checks++; if (reg_addr !== 17'd2) begin errors++; $display("FAIL load_addr: got %h want 2", reg_addr); end
        checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL load_issue_hs: got rdy=%b v=%b want 0/0", req_ready, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || reg_sel !== 3'b000) begin errors++; $display("FAIL load_wait: got v=%b sel=%b want 0/000", rsp_valid, reg_sel); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rsp: got v=%b e=%b d=%h want 1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL load_rsp_ready: got %b want 1", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_rsp_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_store_stack();
        req_valid = 1'b1; req_addr = 32'h7FFF_EFF8; req_wen = 1'b1; req_wdata = 32'h0000_1234;
        tick();
        req_valid = 1'b0; req_wen = 1'b0;
        checks++; if (reg_sel !== 3'b010 || reg_wen !== 3'b010) begin errors++; $display("FAIL store_sel: got sel=%b wen=%b want 010/010", reg_sel, reg_wen); end
        checks++; if (reg_addr !== 17'd1 || reg_wdata !== 32'h0000_1234) begin errors++; $display("FAIL store_addr: got a=%h d=%h want 1/1234", reg_addr, reg_wdata); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL store_rsp: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (reg_sel !== 3'b000) begin errors++; $display("FAIL store_sel_drop: got %b want 000", reg_sel); end
        tick();
    endtask

    task automatic test_faults();
        req_valid = 1'b1; req_addr = 32'h2000_0000;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL miss_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (reg_sel !== 3'b000 || req_ready !== 1'b1) begin errors++; $display("FAIL miss_nostrobe: got sel=%b rdy=%b want 000/1", reg_sel, req_ready); end
        checks++; if (fault_sticky !== 1'b1 || fault_addr !== 32'h2000_0000) begin errors++; $display("FAIL miss_log: got %b %h want 1 20000000", fault_sticky, fault_addr); end
        req_addr = 32'h1001_0001;
        tick();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL misalign_rsp: got v=%b e=%b want 1/1", rsp_valid, rsp_err); end
        checks++; if (fault_addr !== 32'h2000_0000) begin errors++; $display("FAIL first_fault_held: got %h want 20000000", fault_addr); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_fault_clr();
        req_valid = 1'b1; req_addr = 32'h0000_0004; fault_clr = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (fault_sticky !== 1'b1 || fault_addr !== 32'h0000_0004) begin errors++; $display("FAIL clr_with_fault: got %b %h want 1 00000004", fault_sticky, fault_addr); end
        tick();
        fault_clr = 1'b0;
        checks++; if (fault_sticky !== 1'b0 || fault_addr !== 32'h0000_0004) begin errors++; $display("FAIL clr_alone: got %b %h want 0 00000004", fault_sticky, fault_addr); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_addr = 32'hFFFF_0A60; req_wen = 1'b0;
        tick();
        req_addr = 32'h1001_0004;
        checks++; if (reg_sel !== 3'b100 || reg_addr !== 17'h298) begin errors++; $display("FAIL mmio_issue: got sel=%b a=%h want 100/298", reg_sel, reg_addr); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mmio_ready_t1: got %b want 0", req_ready); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mmio_busy_t%0d: got rdy=%b v=%b want 0/0", c, req_ready, rsp_valid); end
        end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || req_ready !== 1'b1) begin errors++; $display("FAIL mmio_rsp: got v=%b d=%h rdy=%b want 1/cafef00d/1", rsp_valid, rsp_rdata, req_ready); end
        checks++; if (reg_addr !== 17'h298) begin errors++; $display("FAIL mmio_rsp_addr: got %h want 298", reg_addr); end
        tick();
        req_valid = 1'b0;
        checks++; if (reg_sel !== 3'b001 || reg_addr !== 17'd1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_issue: got sel=%b a=%h v=%b want 001/1/0", reg_sel, reg_addr, rsp_valid); end
        tick(); tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_rsp: got v=%b d=%h want 1/deadbeef", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        req_valid = 1'b1; req_addr = 32'hFFFF_0000; req_wen = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b0 || reg_sel !== 3'b000 || req_ready !== 1'b0) begin errors++; $display("FAIL midrst: got v=%b sel=%b rdy=%b want 0/000/0", rsp_valid, reg_sel, req_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d responses want 0", seen); end
    endtask

    task automatic test_boundaries();
        req_valid = 1'b1; req_addr = 32'hFFFF_FFFC; req_wen = 1'b0;
        tick();
        checks++; if (rsp_err !== 1'b1 || fault_sticky !== 1'b1 || fault_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL top_addr: got e=%b s=%b a=%h want 1/1/fffffffc", rsp_err, fault_sticky, fault_addr); end
        req_addr = 32'hFFFF_0A64;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin errors++; $display("FAIL past_mmio_limit: got v=%b e=%b want 1/1", rsp_valid, rsp_err); end
        req_addr = 32'h1006_FFFC;
        tick();
        req_valid = 1'b0;
        checks++; if (reg_sel !== 3'b001 || reg_addr !== 17'h17FFF) begin errors++; $display("FAIL data_limit: got sel=%b a=%h want 001/17fff", reg_sel, reg_addr); end
        tick(); tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL data_limit_rsp: got v=%b e=%b want 1/0", rsp_valid, rsp_err); end
        req_valid = 1'b1; req_addr = 32'h7FFE_F000; req_wen = 1'b1; req_wdata = 32'hA5A5_0001;
        tick();
        req_valid = 1'b0; req_wen = 1'b0;
        checks++; if (reg_wen !== 3'b010 || reg_addr !== 17'h3FFF) begin errors++; $display("FAIL stack_base: got wen=%b a=%h want 010/3fff", reg_wen, reg_addr); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_load_data();
        test_store_stack();
        test_faults();
        test_fault_clr();
        test_back_to_back();
        test_reset_mid();
        test_boundaries();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
